serial_deserializer: RTL and testbench
======================================

SERIAL_DESERIALIZER -- requirements
Module: serial_deserializer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the number of data bits per word; legal range 2..32.
REQ-002 The block SHALL have parameter MSB_FIRST, default 1; 1 means the first received bit lands in DOUT[WIDTH-1], 0 means it lands in DOUT[0].
REQ-003 CLK  input  1  single clock; all state changes on its rising edge.
REQ-004 RESET_N  input  1  asynchronous, active-low reset.
REQ-005 SIN  input  1  serial data bit, sampled only when SHIFT=1.
REQ-006 SHIFT  input  1  bit strobe; one bit is accepted per CLK edge with SHIFT=1.
REQ-007 START  input  1  frame-start pulse; opens a new frame.
REQ-008 DREADY  input  1  consumer ready for the held word.
REQ-009 DOUT  output  WIDTH  assembled parallel word.
REQ-010 DVALID  output  1  DOUT holds a complete word.
REQ-011 OVERRUN  output  1  sticky flag: a bit or START arrived while a word was held.
REQ-012 PAR_ERR  output  1  parity-check result, qualified by DVALID.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, RECV and FULL.
REQ-014 IDLE with START=1 SHALL go to RECV with bit count 0; if SHIFT=1 on the same edge, that bit SHALL be captured as bit 1.
REQ-015 IDLE with START=0 SHALL ignore SHIFT.
REQ-016 RECV with SHIFT=1 SHALL capture SIN into the internal shift register and increment the count.
REQ-017 START=1 in RECV SHALL discard the partial frame; if SHIFT=1 on the same edge, that bit SHALL be captured as the new bit 1.
REQ-018 On the edge that captures the final frame bit, the block SHALL load DOUT, set DVALID=1 and enter FULL; DVALID is high in the cycle after that edge, with no further latency.
REQ-019 In FULL, DOUT and DVALID SHALL stay stable until an edge with DREADY=1.
REQ-020 FULL with DREADY=1 SHALL clear DVALID and go to IDLE, or go to RECV if START=1 on the same edge (with the REQ-014 same-edge SHIFT rule).
REQ-021 SHIFT=1 or START=1 in FULL without DREADY=1 SHALL set OVERRUN and discard the bit; DOUT is not disturbed.
REQ-022 OVERRUN SHALL remain set until reset.
REQ-023 The bit counter SHALL be $clog2(WIDTH+2) bits wide and never wrap within a frame.

Reset
REQ-024 RESET_N=0 SHALL immediately, without a clock, force IDLE, count=0, DOUT=0, DVALID=0, OVERRUN=0 and PAR_ERR=0, including in the middle of a frame.
REQ-025 The first edge after RESET_N rises SHALL be treated as a normal IDLE cycle.

Configuration
REQ-026 With macro DESER_PARITY_EN defined, a frame SHALL be WIDTH+1 bits; the last bit is an even-parity bit, not stored in DOUT.
REQ-027 With DESER_PARITY_EN defined, PAR_ERR SHALL be loaded with DVALID as the XOR of the data bits and the parity bit.
REQ-028 Without DESER_PARITY_EN, a frame SHALL be WIDTH bits and PAR_ERR SHALL be constant 0.

Structure
REQ-029 The state enum typedef, the state encodings and the count-width helper function SHALL live in shared package deser_pkg.
REQ-030 One sub-module, deser_shiftbit, SHALL be used per register stage; it is a flop with async active-low reset, a shift enable and a neighbour/SIN data select, instantiated WIDTH times.

Verification
REQ-031 WIDTH=8, MSB_FIRST=1: START plus 8 SHIFTs with bits 1,1,0,1,0,0,0,0 -> DOUT=8'hD0 and DVALID=1 the cycle after the 8th SHIFT.
REQ-032 The same stimulus with MSB_FIRST=0 -> DOUT=8'h0B.
REQ-033 Word held with DREADY=0 for 3 cycles, then SHIFT=1 -> DOUT stays 8'hD0, DVALID stays 1, OVERRUN=1.
REQ-034 3 bits, then START, then 8 bits 1,1,0,1,0,0,0,0 -> DOUT=8'hD0 with no partial-bit contamination.
REQ-035 RESET_N low mid-frame, between clock edges -> DOUT=0, DVALID=0 and OVERRUN=0 before the next edge.
REQ-036 DESER_PARITY_EN defined, data 8'hD0 -> PAR_ERR=0 with parity bit 1, PAR_ERR=1 with parity bit 0.

Source files
------------

// File: rtl/deser_pkg.sv
// -----------------------------------------------------------------------------
// deser_pkg
// Shared definitions for the serial deserializer:
//   - FSM state encodings (ST_*) and the state enum built on them
//   - cnt_width(): width of the per-frame bit counter
// Configuration macro used by the block: DESER_PARITY_EN
// -----------------------------------------------------------------------------
package deser_pkg;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RECV = 2'd1;
   localparam logic [1:0] ST_FULL = 2'd2;

   typedef enum logic [1:0] {
      IDLE = ST_IDLE,
      RECV = ST_RECV,
      FULL = ST_FULL
   } deser_state_e;

   // Room for WIDTH data bits plus an optional parity bit without wrapping.
   function automatic int cnt_width(input int width);
      return $clog2(width + 2);
   endfunction

endpackage

// File: rtl/deser_shiftbit.sv
// -----------------------------------------------------------------------------
// deser_shiftbit
// One stage of the deserializer shift register.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset (clears the stage)
//   en         : shift enable; the stage holds its value when low
//   sel_sin    : 1 = load the serial input, 0 = load the neighbour stage
//   nb_i       : neighbour stage output
//   sin_i      : serial data input
//   d_o        : next value of this stage (value after the coming edge)
//   q_o        : current stage value
// -----------------------------------------------------------------------------
module deser_shiftbit
   import deser_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   input  logic sel_sin,
   input  logic nb_i,
   input  logic sin_i,
   output logic d_o,
   output logic q_o
);

   logic bit_d;
   logic bit_q;

   // NOTE: assign a default before any condition so no path leaves bit_d
   // unassigned; otherwise synthesis infers a latch.
   always_comb begin
      bit_d = bit_q;
      if (en) begin
         bit_d = sel_sin ? sin_i : nb_i;
      end
   end

   // NOTE: flops use non-blocking assignments so every register samples the
   // pre-edge values, independent of block ordering.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bit_q <= 1'b0;
      end else begin
         bit_q <= bit_d;
      end
   end

   assign d_o = bit_d;
   assign q_o = bit_q;

endmodule

// File: rtl/serial_deserializer.sv
// -----------------------------------------------------------------------------
// serial_deserializer
// Collects SHIFT-strobed serial bits into a WIDTH-bit word and holds it until
// the consumer accepts it with DREADY.
// Parameters:
//   WIDTH     : data bits per word (2..32)
//   MSB_FIRST : 1 = first bit lands in DOUT[WIDTH-1], 0 = first bit in DOUT[0]
// Ports:
//   CLK, RESET_N : clock, asynchronous active-low reset
//   SIN, SHIFT   : serial data and its bit strobe
//   START        : opens a new frame (discards any partial frame)
//   DREADY       : consumer accepts the held word
//   DOUT, DVALID : assembled word and its valid flag
//   OVERRUN      : sticky, a bit or START arrived while a word was held
//   PAR_ERR      : parity check result, qualified by DVALID
// Macro DESER_PARITY_EN: frame carries a trailing even-parity bit that is
// checked into PAR_ERR; without it PAR_ERR is tied low.
// -----------------------------------------------------------------------------
module serial_deserializer
   import deser_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter int MSB_FIRST = 1
)
(
   input  logic             CLK,
   input  logic             RESET_N,
   input  logic             SIN,
   input  logic             SHIFT,
   input  logic             START,
   input  logic             DREADY,
   output logic [WIDTH-1:0] DOUT,
   output logic             DVALID,
   output logic             OVERRUN,
   output logic             PAR_ERR
);

   localparam int CW = cnt_width(WIDTH);
`ifdef DESER_PARITY_EN
   localparam int FRAME_LEN = WIDTH + 1;
`else
   localparam int FRAME_LEN = WIDTH;
`endif
   localparam logic [CW-1:0] LAST_IDX  = CW'(FRAME_LEN - 1);
   localparam logic [CW-1:0] DATA_BITS = CW'(WIDTH);

   deser_state_e     state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] dout_q, dout_d;
   logic             dvalid_q, dvalid_d;
   logic             overrun_q, overrun_d;

   logic [WIDTH-1:0] sr_q;
   logic [WIDTH-1:0] sr_nxt;
   logic [WIDTH-1:0] frame_word;

   logic             take_start;
   logic             bit_take;
   logic             last_bit;
   logic             sr_shift;
   logic [CW-1:0]    cnt_base;

   // ---------------------------------------------------------------------------
   // Shift register: the edge stage takes SIN, the others take their neighbour.
   // A full frame rewrites every stage, so restarting never needs a clear.
   // ---------------------------------------------------------------------------
   for (genvar i = 0; i < WIDTH; i++) begin : g_stage
      localparam bit IS_EDGE = (MSB_FIRST != 0) ? (i == 0) : (i == WIDTH - 1);
      logic nb;

      if (IS_EDGE) begin : g_edge
         assign nb = 1'b0;
      end else if (MSB_FIRST != 0) begin : g_msb
         assign nb = sr_q[i-1];
      end else begin : g_lsb
         assign nb = sr_q[i+1];
      end

      deser_shiftbit u_bit (
         .clk     (CLK),
         .rst_n   (RESET_N),
         .en      (sr_shift),
         .sel_sin (1'(IS_EDGE)),
         .nb_i    (nb),
         .sin_i   (SIN),
         .d_o     (sr_nxt[i]),
         .q_o     (sr_q[i])
      );
   end

   // ---------------------------------------------------------------------------
   // Frame bookkeeping
   // ---------------------------------------------------------------------------
   always_comb begin
      // START is honoured everywhere except a held word not being released.
      take_start = START && ((state_q != FULL) || DREADY);
      bit_take   = SHIFT && (take_start || (state_q == RECV));
      // A same-edge START restarts the count, so the bit becomes bit 1.
      cnt_base   = take_start ? '0 : cnt_q;
      last_bit   = bit_take && (cnt_base == LAST_IDX);
      // The parity bit is counted but never enters the shift register.
      sr_shift   = bit_take && (cnt_base < DATA_BITS);
   end

`ifdef DESER_PARITY_EN
   // Data bits are already in place when the parity bit arrives.
   assign frame_word = sr_q;
`else
   // The final data bit is still on its way into the register this edge.
   assign frame_word = sr_nxt;
`endif

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      dout_d    = dout_q;
      dvalid_d  = dvalid_q;
      overrun_d = overrun_q;

      if (state_q == FULL) begin
         if (DREADY) begin
            dvalid_d = 1'b0;
            state_d  = IDLE;
         end else if (SHIFT || START) begin
            overrun_d = 1'b1;
         end
      end

      if (last_bit) begin
         state_d  = FULL;
         cnt_d    = '0;
         dvalid_d = 1'b1;
         dout_d   = frame_word;
      end else if (bit_take) begin
         state_d  = RECV;
         cnt_d    = cnt_base + CW'(1);
      end else if (take_start) begin
         state_d  = RECV;
         cnt_d    = '0;
      end
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         dout_q    <= '0;
         dvalid_q  <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         dout_q    <= dout_d;
         dvalid_q  <= dvalid_d;
         overrun_q <= overrun_d;
      end
   end

`ifdef DESER_PARITY_EN
   logic par_err_q, par_err_d;

   // Even parity: XOR over data and parity bit is 0 for a clean frame.
   always_comb begin
      par_err_d = par_err_q;
      if (last_bit) begin
         par_err_d = (^sr_q) ^ SIN;
      end
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         par_err_q <= 1'b0;
      end else begin
         par_err_q <= par_err_d;
      end
   end

   assign PAR_ERR = par_err_q;
`else
   assign PAR_ERR = 1'b0;
`endif

   assign DOUT    = dout_q;
   assign DVALID  = dvalid_q;
   assign OVERRUN = overrun_q;

endmodule

// File: tb/tb_serial_deserializer.sv
// -----------------------------------------------------------------------------
// tb_serial_deserializer
// Directed bench for serial_deserializer. Two instances share the stimulus:
// dut_m (MSB_FIRST=1) and dut_l (MSB_FIRST=0), both WIDTH=8.
// Inputs change on the falling edge; outputs are checked there too.
// Honours DESER_PARITY_EN when the bundle is built with it.
// -----------------------------------------------------------------------------
module tb_serial_deserializer;

   logic       CLK     = 1'b0;
   logic       RESET_N = 1'b0;
   logic       SIN     = 1'b0;
   logic       SHIFT   = 1'b0;
   logic       START   = 1'b0;
   logic       DREADY  = 1'b0;

   logic [7:0] dout_m, dout_l;
   logic       dvalid_m, dvalid_l;
   logic       ovr_m, ovr_l;
   logic       perr_m, perr_l;

   int vectors     = 0;
   int miscompares = 0;

   always #5 CLK = ~CLK;

   serial_deserializer #(.WIDTH(8), .MSB_FIRST(1)) dut_m (
      .CLK     (CLK),
      .RESET_N (RESET_N),
      .SIN     (SIN),
      .SHIFT   (SHIFT),
      .START   (START),
      .DREADY  (DREADY),
      .DOUT    (dout_m),
      .DVALID  (dvalid_m),
      .OVERRUN (ovr_m),
      .PAR_ERR (perr_m)
   );

   serial_deserializer #(.WIDTH(8), .MSB_FIRST(0)) dut_l (
      .CLK     (CLK),
      .RESET_N (RESET_N),
      .SIN     (SIN),
      .SHIFT   (SHIFT),
      .START   (START),
      .DREADY  (DREADY),
      .DOUT    (dout_l),
      .DVALID  (dvalid_l),
      .OVERRUN (ovr_l),
      .PAR_ERR (perr_l)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      @(negedge CLK);
   endtask

   task automatic shift_bit(input logic b);
      SHIFT = 1'b1;
      SIN   = b;
      tick();
      SHIFT = 1'b0;
      SIN   = 1'b0;
   endtask

   // Parity bit, when the frame carries one.
   task automatic finish_frame(input logic par);
`ifdef DESER_PARITY_EN
      check("pre_parity_dvalid", 32'(dvalid_m), 32'd0);
      shift_bit(par);
`else
      SIN = par & 1'b0;
`endif
   endtask

   // Sends seq[first] down to seq[0]; checks DVALID stays low until the end.
   task automatic frame_rest(input logic [7:0] seq, input logic par, input int first, input string tag);
      for (int i = first; i >= 1; i--) shift_bit(seq[i]);
      check({tag, "_dvalid_early"}, 32'(dvalid_m), 32'd0);
      shift_bit(seq[0]);
      finish_frame(par);
      check({tag, "_dvalid_m"}, 32'(dvalid_m), 32'd1);
      check({tag, "_dvalid_l"}, 32'(dvalid_l), 32'd1);
   endtask

   initial begin
      // ---- reset state ----
      #12;
      check("rst_dout_m",   32'(dout_m),   32'h00);
      check("rst_dvalid_m", 32'(dvalid_m), 32'd0);
      check("rst_ovr_m",    32'(ovr_m),    32'd0);
      check("rst_perr_m",   32'(perr_m),   32'd0);
      @(negedge CLK);
      RESET_N = 1'b1;

      // ---- IDLE ignores SHIFT without START ----
      SHIFT = 1'b1; SIN = 1'b1;
      tick(); tick(); tick();
      SHIFT = 1'b0; SIN = 1'b0;
      check("idle_dvalid", 32'(dvalid_m), 32'd0);
      check("idle_ovr",    32'(ovr_m),    32'd0);

      // ---- basic frame 1,1,0,1,0,0,0,0 ----
      START = 1'b1; tick(); START = 1'b0;
      frame_rest(8'hD0, 1'b1, 7, "f1");
      check("f1_dout_m", 32'(dout_m), 32'hD0);
      check("f1_dout_l", 32'(dout_l), 32'h0B);
      check("f1_perr",   32'(perr_m), 32'd0);
      check("f1_ovr",    32'(ovr_m),  32'd0);

      // ---- hold with DREADY=0, then an overrun bit ----
      tick(); tick(); tick();
      check("hold_dout",   32'(dout_m),   32'hD0);
      check("hold_dvalid", 32'(dvalid_m), 32'd1);
      shift_bit(1'b0);
      check("ovr_dout_m",  32'(dout_m),   32'hD0);
      check("ovr_dout_l",  32'(dout_l),   32'h0B);
      check("ovr_dvalid",  32'(dvalid_m), 32'd1);
      check("ovr_flag_m",  32'(ovr_m),    32'd1);
      check("ovr_flag_l",  32'(ovr_l),    32'd1);

      // ---- release, OVERRUN stays sticky ----
      DREADY = 1'b1; tick(); DREADY = 1'b0;
      check("rel_dvalid", 32'(dvalid_m), 32'd0);
      check("rel_ovr",    32'(ovr_m),    32'd1);

      // ---- 3 partial bits, restart with START+SHIFT on the same edge ----
      START = 1'b1; tick(); START = 1'b0;
      shift_bit(1'b0); shift_bit(1'b1); shift_bit(1'b1);
      START = 1'b1;
      shift_bit(1'b1);
      START = 1'b0;
      frame_rest(8'hD0, 1'b1, 6, "f2");
      check("f2_dout_m", 32'(dout_m), 32'hD0);
      check("f2_dout_l", 32'(dout_l), 32'h0B);

      // ---- FULL with DREADY+START+SHIFT: straight into a new frame ----
      DREADY = 1'b1; START = 1'b1;
      shift_bit(1'b0);
      DREADY = 1'b0; START = 1'b0;
      check("f3_dvalid_clr", 32'(dvalid_m), 32'd0);
      frame_rest(8'h39, 1'b0, 6, "f3");
      check("f3_dout_m", 32'(dout_m), 32'h39);
      check("f3_dout_l", 32'(dout_l), 32'h9C);
      check("f3_perr",   32'(perr_m), 32'd0);

`ifdef DESER_PARITY_EN
      // ---- wrong parity bit on 8'hD0 ----
      DREADY = 1'b1; tick(); DREADY = 1'b0;
      START = 1'b1; tick(); START = 1'b0;
      frame_rest(8'hD0, 1'b0, 7, "f4");
      check("f4_dout_m", 32'(dout_m), 32'hD0);
      check("f4_perr_m", 32'(perr_m), 32'd1);
      check("f4_perr_l", 32'(perr_l), 32'd1);
`endif

      // ---- asynchronous reset in the middle of a frame ----
      DREADY = 1'b1; tick(); DREADY = 1'b0;
      START = 1'b1; tick(); START = 1'b0;
      shift_bit(1'b1); shift_bit(1'b0); shift_bit(1'b1); shift_bit(1'b0);
      #2 RESET_N = 1'b0;
      #1;
      check("mid_rst_dout_m", 32'(dout_m),   32'h00);
      check("mid_rst_dout_l", 32'(dout_l),   32'h00);
      check("mid_rst_dvalid", 32'(dvalid_m), 32'd0);
      check("mid_rst_ovr_m",  32'(ovr_m),    32'd0);
      check("mid_rst_ovr_l",  32'(ovr_l),    32'd0);
      check("mid_rst_perr",   32'(perr_m),   32'd0);

      // ---- first edge after reset is a normal IDLE cycle ----
      @(negedge CLK);
      RESET_N = 1'b1;
      START   = 1'b1;
      shift_bit(1'b1);
      START   = 1'b0;
      frame_rest(8'hD0, 1'b1, 6, "f5");
      check("f5_dout_m", 32'(dout_m), 32'hD0);
      check("f5_dout_l", 32'(dout_l), 32'h0B);
      check("f5_ovr",    32'(ovr_m),  32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
